// File: rtl/hsv_mem_axi_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axib_if
// Description : AXI bus bundle between the core memory port and a memory
//               subordinate. Carries the AR, R, AW, W and B channels with
//               32-bit addresses and data, 4-bit byte strobes and 4-bit IDs.
//   modport s : subordinate view (drives ready/response side)
//   modport m : master view (drives request side)
// Revision    : 1.0 - initial release
// ============================================================================
interface axib_if;
   // Read address channel
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   // Read data channel
   logic        rvalid;
   logic        rready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   // Write address channel
   logic        awvalid;
   logic        awready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   // Write data channel
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   // Write response channel
   logic        bvalid;
   logic        bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;

   modport s (
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready,
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready
   );

   modport m (
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready,
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready
   );
endinterface
`default_nettype wire

// File: rtl/hsv_mem_axi_responder.sv
`default_nettype none
// ============================================================================
// Module      : hsv_mem_axi_responder
// Description : AXI subordinate terminating the core memory bus on a
//               word-addressed SRAM array. One transaction at a time; INCR
//               bursts of 4-byte beats; out-of-range or unsupported beats
//               answer SLVERR.
//   clk_core  : core clock
//   rst_core  : synchronous active-high reset
//   mem       : axib_if subordinate modport (AR, R, AW, W, B)
// Parameters  : ADDR_BASE (byte address of word 0), DEPTH_WORDS (power of
//               two), READ_LATENCY (>=1, AR handshake to first rvalid),
//               INIT_FILE (array preload name for tool flows; empty = none)
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_mem_axi_responder #(
   parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          READ_LATENCY = 1,
   parameter string       INIT_FILE    = ""
) (
   input logic clk_core,
   input logic rst_core,
   axib_if.s   mem
);

   localparam int          c_AW          = $clog2(DEPTH_WORDS);
   localparam logic [15:0] c_LAT_INIT    = 16'(READ_LATENCY - 1);

   localparam logic [2:0]  c_IDLE        = 3'd0;
   localparam logic [2:0]  c_RD_WAIT     = 3'd1;
   localparam logic [2:0]  c_RD_DATA     = 3'd2;
   localparam logic [2:0]  c_WR_DATA     = 3'd3;
   localparam logic [2:0]  c_WR_RESP     = 3'd4;

   localparam logic [1:0]  c_OKAY        = 2'b00;
   localparam logic [1:0]  c_SLVERR      = 2'b10;
   localparam logic [2:0]  c_SIZE_4B     = 3'b010;
   localparam logic [1:0]  c_BURST_INCR  = 2'b01;

   logic [31:0] ram_q [DEPTH_WORDS];

   logic [2:0]  state_q, state_d;
   logic        prio_rd_q, prio_rd_d;
   logic [3:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [8:0]  beats_q, beats_d;
   logic [15:0] lat_q, lat_d;
   logic        bad_q, bad_d;       // burst attributes unsupported
   logic        werr_q, werr_d;     // sticky write-burst error
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rlast_q, rlast_d;
   logic [1:0]  bresp_q, bresp_d;

   logic        w_arready, w_awready, w_wready;
   logic        w_ar_hs, w_aw_hs, w_w_hs;
   logic        rd_load;
   logic [31:0] rd_off, wr_off;
   logic        rd_beat_err, wr_beat_err;
   logic        ram_we;
   logic [c_AW-1:0] ram_widx;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wstrb;

   // Ready terms are held low while reset is asserted so no handshake can
   // complete on the reset edge.
   assign w_arready = (state_q == c_IDLE) & ~rst_core & (~mem.awvalid | prio_rd_q);
   assign w_awready = (state_q == c_IDLE) & ~rst_core & (~mem.arvalid | ~prio_rd_q);
   assign w_wready  = (state_q == c_WR_DATA) & ~rst_core;

   assign w_ar_hs   = mem.arvalid & w_arready;
   assign w_aw_hs   = mem.awvalid & w_awready;
   assign w_w_hs    = mem.wvalid & w_wready;

   assign mem.arready = w_arready;
   assign mem.awready = w_awready;
   assign mem.wready  = w_wready;
   assign mem.rvalid  = (state_q == c_RD_DATA);
   assign mem.rid     = id_q;
   assign mem.rdata   = rdata_q;
   assign mem.rresp   = rresp_q;
   assign mem.rlast   = rlast_q;
   assign mem.bvalid  = (state_q == c_WR_RESP);
   assign mem.bid     = id_q;
   assign mem.bresp   = bresp_q;

   always_comb begin
      state_d     = state_q;
      prio_rd_d   = prio_rd_q;
      id_d        = id_q;
      addr_d      = addr_q;
      beats_d     = beats_q;
      lat_d       = lat_q;
      bad_d       = bad_q;
      werr_d      = werr_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      bresp_d     = bresp_q;
      rd_load     = 1'b0;
      rd_off      = '0;
      rd_beat_err = 1'b0;
      ram_we      = 1'b0;
      ram_wdata   = mem.wdata;
      ram_wstrb   = mem.wstrb;

      // Offset arithmetic wraps at 32 bits, so addresses below the base
      // become huge offsets and fall out of range naturally.
      wr_off      = addr_q - ADDR_BASE;
      wr_beat_err = bad_q | (wr_off[31:c_AW+2] != '0);
      ram_widx    = wr_off[c_AW+1:2];

      case (state_q)
         c_IDLE: begin
            if (w_ar_hs) begin
               prio_rd_d = ~prio_rd_q;
               id_d      = mem.arid;
               addr_d    = mem.araddr;
               beats_d   = {1'b0, mem.arlen} + 9'd1;
               bad_d     = (mem.arsize != c_SIZE_4B) | (mem.arburst != c_BURST_INCR);
               if (c_LAT_INIT == 16'd0) begin
                  state_d = c_RD_DATA;
                  rd_load = 1'b1;
               end else begin
                  state_d = c_RD_WAIT;
                  lat_d   = c_LAT_INIT;
               end
            end else if (w_aw_hs) begin
               prio_rd_d = ~prio_rd_q;
               id_d      = mem.awid;
               addr_d    = mem.awaddr;
               bad_d     = (mem.awsize != c_SIZE_4B) | (mem.awburst != c_BURST_INCR);
               werr_d    = 1'b0;
               state_d   = c_WR_DATA;
            end
         end
         c_RD_WAIT: begin
            // The data register is loaded on the transition into RD_DATA,
            // so the final wait cycle is the one with the counter at 1.
            if (lat_q <= 16'd1) begin
               state_d = c_RD_DATA;
               rd_load = 1'b1;
            end else begin
               lat_d = lat_q - 16'd1;
            end
         end
         c_RD_DATA: begin
            if (mem.rready) begin
               if (beats_q == 9'd1) begin
                  state_d = c_IDLE;
               end else begin
                  beats_d = beats_q - 9'd1;
                  addr_d  = addr_q + 32'd4;
                  rd_load = 1'b1;
               end
            end
         end
         c_WR_DATA: begin
            if (w_w_hs) begin
               ram_we = ~wr_beat_err;
               werr_d = werr_q | wr_beat_err;
               addr_d = addr_q + 32'd4;
               if (mem.wlast) begin
                  state_d = c_WR_RESP;
                  bresp_d = (werr_q | wr_beat_err) ? c_SLVERR : c_OKAY;
               end
            end
         end
         c_WR_RESP: begin
            if (mem.bready) begin
               state_d = c_IDLE;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase

      // Registered read beat: fetched for the address the next beat will
      // present, so R outputs stay stable throughout a stall.
      if (rd_load) begin
         rd_off      = addr_d - ADDR_BASE;
         rd_beat_err = bad_d | (rd_off[31:c_AW+2] != '0);
         rdata_d     = rd_beat_err ? 32'd0 : ram_q[rd_off[c_AW+1:2]];
         rresp_d     = rd_beat_err ? c_SLVERR : c_OKAY;
         rlast_d     = (beats_d == 9'd1);
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_q   <= c_IDLE;
         prio_rd_q <= 1'b1;
         id_q      <= '0;
         addr_q    <= '0;
         beats_q   <= '0;
         lat_q     <= '0;
         bad_q     <= 1'b0;
         werr_q    <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= c_OKAY;
         rlast_q   <= 1'b0;
         bresp_q   <= c_OKAY;
      end else begin
         state_q   <= state_d;
         prio_rd_q <= prio_rd_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         beats_q   <= beats_d;
         lat_q     <= lat_d;
         bad_q     <= bad_d;
         werr_q    <= werr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         bresp_q   <= bresp_d;
      end
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge clk_core) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_wstrb[b]) begin
               ram_q[ram_widx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hsv_mem_axi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsv_mem_axi_responder
// Description : Self-checking bench for hsv_mem_axi_responder. A flat word
//               array model tracks memory contents; directed steps cover
//               reset, strobes, stalls, arbitration, range errors, address
//               wrap and mid-burst reset, followed by random transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsv_mem_axi_responder;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          D    = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axib_if bus ();

   hsv_mem_axi_responder #(
      .ADDR_BASE    (BASE),
      .DEPTH_WORDS  (D),
      .READ_LATENCY (1),
      .INIT_FILE    ("")
   ) dut (
      .clk_core (clk),
      .rst_core (rst),
      .mem      (bus)
   );

   int          n_run;
   int          n_fail;
   logic [31:0] model [D];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit inr(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < 32'(4 * D);
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off >> 2);
   endfunction

   task automatic idle_master();
      bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
      bus.rready  = 0;
      bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
      bus.wvalid  = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
      bus.bready  = 0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rnd,
                           input logic [31:0] fdata, input logic [3:0] fstrb, input bit gaps);
      bit          bad;
      bit          err;
      int          g;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      bad = (size != 3'b010) || (burst != 2'b01);
      err = 0;
      @(posedge clk); #1;
      bus.awvalid = 1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
      bus.awsize = size; bus.awburst = burst;
      g = 0;
      @(negedge clk);
      while (!bus.awready && g < 50) begin g++; @(negedge clk); end
      if (!bus.awready) begin
         chk("aw_timeout", 32'(bus.awready), 32'd1);
         bus.awvalid = 0;
         return;
      end
      chk("w_before_aw", 32'(bus.wready), 32'd0);
      @(posedge clk); #1;
      bus.awvalid = 0;
      for (int b = 0; b <= len; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.wvalid = 0;
            @(posedge clk); #1;
         end
         d = rnd ? $urandom : fdata;
         s = rnd ? 4'($urandom) : fstrb;
         bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = (b == len);
         g = 0;
         @(negedge clk);
         while (!bus.wready && g < 50) begin g++; @(negedge clk); end
         if (!bus.wready) begin
            chk("w_timeout", 32'(bus.wready), 32'd1);
            bus.wvalid = 0; bus.wlast = 0;
            return;
         end
         a = addr + 32'(4 * b);
         if (!bad && inr(a)) begin
            for (int k = 0; k < 4; k++)
               if (s[k]) model[widx(a)][8*k +: 8] = d[8*k +: 8];
         end else begin
            err = 1;
         end
         @(posedge clk); #1;
      end
      bus.wvalid = 0; bus.wlast = 0;
      @(negedge clk);
      chk("b_valid_rise", 32'(bus.bvalid), 32'd1);
      chk("b_id", 32'(bus.bid), 32'(id));
      chk("b_resp", 32'(bus.bresp), err ? 32'd2 : 32'd0);
      g = $urandom_range(0, 2);
      for (int h = 0; h < g; h++) begin
         @(negedge clk);
         chk("b_hold", 32'(bus.bvalid), 32'd1);
      end
      @(posedge clk); #1;
      bus.bready = 1;
      @(posedge clk); #1;
      bus.bready = 0;
      @(negedge clk);
      chk("b_drop", 32'(bus.bvalid), 32'd0);
   endtask

   // mode 0: rready always high, 1: toggling 1/0, 2: random
   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
      bit          bad;
      int          beat;
      int          cyc;
      int          g;
      logic [31:0] a;
      logic [31:0] ed;
      logic [1:0]  er;
      bad = (size != 3'b010) || (burst != 2'b01);
      @(posedge clk); #1;
      bus.arvalid = 1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
      bus.arsize = size; bus.arburst = burst;
      g = 0;
      @(negedge clk);
      while (!bus.arready && g < 50) begin g++; @(negedge clk); end
      if (!bus.arready) begin
         chk("ar_timeout", 32'(bus.arready), 32'd1);
         bus.arvalid = 0;
         return;
      end
      @(posedge clk); #1;
      bus.arvalid = 0;
      beat = 0;
      cyc  = 0;
      while (beat <= len && cyc < 2000) begin
         case (mode)
            0:       bus.rready = 1;
            1:       bus.rready = (cyc % 2 == 0);
            default: bus.rready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (cyc == 0) chk("r_latency", 32'(bus.rvalid), 32'd1);
         if (bus.rvalid) begin
            a = addr + 32'(4 * beat);
            if (!bad && inr(a)) begin ed = model[widx(a)]; er = 2'b00; end
            else                begin ed = 32'd0;          er = 2'b10; end
            chk("r_data", bus.rdata, ed);
            chk("r_resp", 32'(bus.rresp), 32'(er));
            chk("r_last", 32'(bus.rlast), 32'(beat == len));
            chk("r_id", 32'(bus.rid), 32'(id));
            if (bus.rready) beat++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (beat <= len) chk("r_timeout", 32'(beat), 32'(len + 1));
      bus.rready = 0;
      @(negedge clk);
      chk("r_done_rvalid", 32'(bus.rvalid), 32'd0);
      if (!bus.awvalid) chk("r_done_arready", 32'(bus.arready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      int          len;
      int          sel;
      logic [2:0]  sz;
      logic [1:0]  bu;
      n_run  = 0;
      n_fail = 0;
      idle_master();
      rst = 1;

      // ---------------- reset values (ready terms forced low) ----------
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(bus.arready), 32'd0);
      chk("rst_awready", 32'(bus.awready), 32'd0);
      chk("rst_wready",  32'(bus.wready),  32'd0);
      chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
      chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
      chk("rst_rlast",   32'(bus.rlast),   32'd0);
      chk("rst_rdata",   bus.rdata,        32'd0);
      chk("rst_rresp",   32'(bus.rresp),   32'd0);
      chk("rst_bresp",   32'(bus.bresp),   32'd0);
      chk("rst_rid",     32'(bus.rid),     32'd0);
      chk("rst_bid",     32'(bus.bid),     32'd0);
      @(posedge clk); #1;
      rst = 0;

      // ---------------- preload whole array with one burst --------------
      do_write(BASE, 4'd1, D - 1, 3'b010, 2'b01, 1, 32'd0, 4'h0, 0);

      // ---------------- single-beat read of word 4 ----------------------
      do_read(32'h10, 4'd3, 0, 3'b010, 2'b01, 0);

      // ---------------- strobed write merge ------------------------------
      do_write(32'h20, 4'd5, 0, 3'b010, 2'b01, 0, 32'h1122_3344, 4'hF, 0);
      do_write(32'h20, 4'd6, 0, 3'b010, 2'b01, 0, 32'hDEAD_BEEF, 4'b0101, 0);
      do_read(32'h20, 4'd6, 0, 3'b010, 2'b01, 0);
      @(posedge clk); #1;
      bus.arvalid = 1; bus.arid = 4'd2; bus.araddr = 32'h20; bus.arlen = 0;
      bus.arsize = 3'b010; bus.arburst = 2'b01;
      @(posedge clk); #1;
      bus.arvalid = 0; bus.rready = 1;
      @(negedge clk);
      chk("merge_literal", bus.rdata, 32'h11AD_33EF);
      @(posedge clk); #1;
      bus.rready = 0;

      // ---------------- 4-beat burst with toggling rready ----------------
      do_read(32'h0, 4'd7, 3, 3'b010, 2'b01, 1);

      // ---------------- unsupported size / burst -------------------------
      do_write(32'h30, 4'd2, 1, 3'b001, 2'b01, 1, 32'd0, 4'h0, 0);
      do_read(32'h30, 4'd2, 1, 3'b010, 2'b10, 0);
      do_read(32'h30, 4'd4, 0, 3'b011, 2'b01, 0);

      // ---------------- out-of-range accesses ----------------------------
      do_write(BASE + 32'(4 * D), 4'd7, 0, 3'b010, 2'b01, 1, 32'd0, 4'h0, 0);
      do_write(BASE + 32'(4 * D) - 32'd8, 4'd8, 3, 3'b010, 2'b01, 1, 32'd0, 4'h0, 1);
      do_read(BASE + 32'(4 * D) - 32'd4, 4'd1, 1, 3'b010, 2'b01, 0);
      do_read(32'hFFFF_FFF8, 4'd4, 3, 3'b010, 2'b01, 2);

      // ---------------- arbitration after a fresh reset ------------------
      @(posedge clk); #1;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      bus.arvalid = 1; bus.arid = 4'd9;  bus.araddr = 32'h40; bus.arlen = 0;
      bus.arsize = 3'b010; bus.arburst = 2'b01;
      bus.awvalid = 1; bus.awid = 4'd10; bus.awaddr = 32'h44; bus.awlen = 0;
      bus.awsize = 3'b010; bus.awburst = 2'b01;
      @(negedge clk);
      chk("arb1_arready", 32'(bus.arready), 32'd1);
      chk("arb1_awready", 32'(bus.awready), 32'd0);
      @(posedge clk); #1;
      bus.arvalid = 0; bus.rready = 1;
      @(negedge clk);
      chk("arb1_rvalid", 32'(bus.rvalid), 32'd1);
      chk("arb1_rdata", bus.rdata, model[16]);
      chk("arb1_awready_busy", 32'(bus.awready), 32'd0);
      @(posedge clk); #1;
      bus.rready = 0;
      bus.arvalid = 1; bus.arid = 4'd11; bus.araddr = 32'h44;
      @(negedge clk);
      chk("arb2_awready", 32'(bus.awready), 32'd1);
      chk("arb2_arready", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
      bus.awvalid = 0;
      bus.wvalid = 1; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1;
      @(negedge clk);
      chk("arb2_wready", 32'(bus.wready), 32'd1);
      chk("arb2_arready_busy", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
      model[17] = 32'hCAFE_F00D;
      bus.wvalid = 0; bus.wlast = 0; bus.bready = 1;
      @(negedge clk);
      chk("arb2_bvalid", 32'(bus.bvalid), 32'd1);
      chk("arb2_bid", 32'(bus.bid), 32'd10);
      chk("arb2_bresp", 32'(bus.bresp), 32'd0);
      @(posedge clk); #1;
      bus.bready = 0;
      @(negedge clk);
      chk("arb3_arready", 32'(bus.arready), 32'd1);
      @(posedge clk); #1;
      bus.arvalid = 0; bus.rready = 1;
      @(negedge clk);
      chk("arb3_rvalid", 32'(bus.rvalid), 32'd1);
      chk("arb3_rdata", bus.rdata, 32'hCAFE_F00D);
      chk("arb3_rid", 32'(bus.rid), 32'd11);
      @(posedge clk); #1;
      bus.rready = 0;

      // ---------------- reset in the middle of a read burst --------------
      bus.arvalid = 1; bus.arid = 4'd12; bus.araddr = 32'h0; bus.arlen = 3;
      bus.arsize = 3'b010; bus.arburst = 2'b01;
      @(negedge clk);
      chk("mid_arready", 32'(bus.arready), 32'd1);
      @(posedge clk); #1;
      bus.arvalid = 0; bus.rready = 1;
      @(negedge clk);
      chk("mid_beat0", bus.rdata, model[0]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_beat1", bus.rdata, model[1]);
      chk("mid_beat1_last", 32'(bus.rlast), 32'd0);
      @(posedge clk); #1;
      bus.rready = 0;
      rst = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("mid_rst_arready", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      do_read(32'h8, 4'd13, 1, 3'b010, 2'b01, 0);

      // ---------------- random traffic -----------------------------------
      for (int it = 0; it < 40; it++) begin
         len = $urandom_range(0, 7);
         sel = $urandom_range(0, 9);
         if (sel == 0) ra = BASE + 32'(4 * D) - 32'(4 * $urandom_range(0, 3));
         else          ra = BASE + 32'(4 * $urandom_range(0, D - 1)) + 32'($urandom_range(0, 3));
         sz = 3'b010;
         bu = 2'b01;
         if ($urandom_range(0, 9) == 0) sz = 3'b001;
         if ($urandom_range(0, 9) == 0) bu = 2'b10;
         if ($urandom_range(0, 1) == 0)
            do_read(ra, 4'($urandom), len, sz, bu, $urandom_range(0, 2));
         else
            do_write(ra, 4'($urandom), len, sz, bu, 1, 32'd0, 4'h0, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
